stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 34 +++
 rtl/btn_sync.sv | 36 +++
 rtl/stopwatch_ctrl.sv | 96 +++++++++
 tb/tb_stopwatch_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch controller: state encoding, display widths
// and the FSM next-state function.
package stopwatch_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } hms_t;

  // Priority clr > ss > lap; pulses with no transition in a state are dropped.
  function automatic state_e next_state(state_e s, logic ss, logic lp, logic clr);
    next_state = s;
    case (s)
      S_IDLE:  if (ss) next_state = S_RUN;
      S_RUN:   if (ss) next_state = S_PAUSE; else if (lp) next_state = S_LAP;
      S_LAP:   if (ss) next_state = S_PAUSE; else if (lp) next_state = S_RUN;
      S_PAUSE: if (clr) next_state = S_IDLE; else if (ss) next_state = S_RUN;
      default: next_state = S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Button synchronizer (SYNC_STAGES flops) followed by a registered
// rising-edge detector producing a one-cycle pulse.
module btn_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_100MHz,
  input  logic resetn,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], btn};
    prev_d  = sync_q[SYNC_STAGES-1];
    pulse_d = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk_100MHz or negedge resetn) begin
    if (!resetn) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, run/pause/lap FSM, tick prescaler
// and lap display hold. Lap support is built only with STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV    = 100000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_100MHz,
  input  logic              resetn,
  input  logic              start_stop,
  input  logic              lap,
  input  logic              clear,
  input  logic [HOUR_W-1:0] hour_in,
  input  logic [MIN_W-1:0]  min_in,
  input  logic [SEC_W-1:0]  sec_in,
  output logic              count_en,
  output logic              count_clr,
  output logic [HOUR_W-1:0] hour_out,
  output logic [MIN_W-1:0]  min_out,
  output logic [SEC_W-1:0]  sec_out,
  output logic [1:0]        state_out
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          count_clr_q, count_clr_d;
  logic          ss_p, lap_p, clr_p;
  logic          running;
  hms_t          live, shown;

  assign live = '{hour: hour_in, min: min_in, sec: sec_in};

  btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk_100MHz(clk_100MHz), .resetn(resetn), .btn(start_stop), .pulse(ss_p));
  btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clr (
    .clk_100MHz(clk_100MHz), .resetn(resetn), .btn(clear), .pulse(clr_p));

`ifdef STOPWATCH_LAP_EN
  hms_t lat_q, lat_d;

  btn_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lap (
    .clk_100MHz(clk_100MHz), .resetn(resetn), .btn(lap), .pulse(lap_p));

  always_comb begin
    lat_d = lat_q;
    if (state_q != S_LAP && state_d == S_LAP) lat_d = live;
  end

  always_ff @(posedge clk_100MHz or negedge resetn) begin
    if (!resetn) lat_q <= '0;
    else         lat_q <= lat_d;
  end

  assign shown = (state_q == S_LAP) ? lat_q : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign lap_p      = 1'b0;
  assign shown      = live;
`endif

  assign running = (state_q == S_RUN) || (state_q == S_LAP);

  always_comb begin
    state_d     = next_state(state_q, ss_p, lap_p, clr_p);
    count_clr_d = (state_q == S_PAUSE) && (state_d == S_IDLE);
    presc_d     = presc_q;
    // Pause simply holds the count so a resumed run finishes the partial tick.
    if (state_d == S_IDLE)  presc_d = '0;
    else if (running)       presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
  end

  always_ff @(posedge clk_100MHz or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      presc_q     <= '0;
      count_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      count_clr_q <= count_clr_d;
    end
  end

  assign count_en  = running && (presc_q == PRESC_MAX);
  assign count_clr = count_clr_q;
  assign state_out = state_q;
  assign hour_out  = shown.hour;
  assign min_out   = shown.min;
  assign sec_out   = shown.sec;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4, SYNC_STAGES=2.
module tb_stopwatch_ctrl;

  logic       clk_100MHz = 1'b0;
  logic       resetn = 1'b0;
  logic       start_stop = 1'b0, lap = 1'b0, clear = 1'b0;
  logic [4:0] hour_in = '0;
  logic [5:0] min_in = '0, sec_in = '0;
  logic       count_en, count_clr;
  logic [4:0] hour_out;
  logic [5:0] min_out, sec_out;
  logic [1:0] state_out;

  int checks = 0;
  int failures = 0;

  stopwatch_ctrl #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk_100MHz(clk_100MHz), .resetn(resetn), .start_stop(start_stop), .lap(lap),
    .clear(clear), .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .count_en(count_en), .count_clr(count_clr), .hour_out(hour_out),
    .min_out(min_out), .sec_out(sec_out), .state_out(state_out));

  always #5 clk_100MHz = ~clk_100MHz;

  task automatic cyc();
    @(posedge clk_100MHz);
    #2;
  endtask

  task automatic do_reset();
    resetn = 1'b0; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    cyc(); cyc();
    resetn = 1'b1;
  endtask

  // One-cycle press; on return the resulting transition has just happened.
  task automatic press(input int which);
    case (which)
      0: start_stop = 1'b1;
      1: lap = 1'b1;
      default: clear = 1'b1;
    endcase
    cyc();
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    cyc(); cyc(); cyc();
  endtask

  task automatic test_reset();
    resetn = 1'b0; hour_in = 5'd3; min_in = 6'd4; sec_in = 6'd5;
    #3;
    checks++; if (state_out !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state_out); end
    checks++; if (count_en !== 1'b0 || count_clr !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", count_en, count_clr); end
    checks++; if ({hour_out, min_out, sec_out} !== {5'd3, 6'd4, 6'd5}) begin failures++; $display("FAIL reset_display got=%0d/%0d/%0d exp=3/4/5", hour_out, min_out, sec_out); end
  endtask

  task automatic test_start_run();
    logic exp_en;
    logic [1:0] exp_st;
    do_reset();
    start_stop = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      exp_st = (i >= 4) ? 2'd1 : 2'd0;
      exp_en = (i >= 4) && (((i - 4) % 4) == 3);
      checks++; if (state_out !== exp_st) begin failures++; $display("FAIL start_state cyc=%0d got=%0d exp=%0d", i, state_out, exp_st); end
      checks++; if (count_en !== exp_en) begin failures++; $display("FAIL start_count_en cyc=%0d got=%b exp=%b", i, count_en, exp_en); end
    end
    start_stop = 1'b0;
  endtask

  task automatic test_held_through_reset();
    logic [1:0] exp_st;
    resetn = 1'b0; start_stop = 1'b1;
    cyc(); cyc();
    resetn = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      exp_st = (i >= 4) ? 2'd1 : 2'd0;
      checks++; if (state_out !== exp_st) begin failures++; $display("FAIL held_reset_state cyc=%0d got=%0d exp=%0d", i, state_out, exp_st); end
    end
    start_stop = 1'b0;
  endtask

  task automatic test_pause_resume();
    do_reset();
    press(0);
    cyc(); cyc();
    press(0);
    checks++; if (state_out !== 2'd2) begin failures++; $display("FAIL pause_state got=%0d exp=2", state_out); end
    for (int i = 0; i < 6; i++) begin
      cyc();
      checks++; if (count_en !== 1'b0 || state_out !== 2'd2) begin failures++; $display("FAIL pause_silent cyc=%0d en=%b st=%0d exp en=0 st=2", i, count_en, state_out); end
    end
    press(0);
    checks++; if (state_out !== 2'd1 || count_en !== 1'b0) begin failures++; $display("FAIL resume_first st=%0d en=%b exp st=1 en=0", state_out, count_en); end
    cyc();
    checks++; if (count_en !== 1'b1) begin failures++; $display("FAIL resume_strobe got=%b exp=1", count_en); end
    cyc();
    checks++; if (count_en !== 1'b0) begin failures++; $display("FAIL resume_after got=%b exp=0", count_en); end
  endtask

  task automatic test_clear_priority();
    do_reset();
    press(0);
    cyc();
    press(0);
    start_stop = 1'b1; clear = 1'b1;
    cyc();
    start_stop = 1'b0; clear = 1'b0;
    cyc(); cyc();
    checks++; if (state_out !== 2'd2 || count_clr !== 1'b0) begin failures++; $display("FAIL clr_pre st=%0d clr=%b exp st=2 clr=0", state_out, count_clr); end
    cyc();
    checks++; if (state_out !== 2'd0 || count_clr !== 1'b1) begin failures++; $display("FAIL clr_enter st=%0d clr=%b exp st=0 clr=1", state_out, count_clr); end
    cyc();
    checks++; if (state_out !== 2'd0 || count_clr !== 1'b0) begin failures++; $display("FAIL clr_once st=%0d clr=%b exp st=0 clr=0", state_out, count_clr); end
    press(0);
    for (int j = 1; j <= 3; j++) begin
      cyc();
      checks++; if (count_en !== (j == 3)) begin failures++; $display("FAIL clr_presc_zero cyc=%0d got=%b exp=%b", j, count_en, (j == 3)); end
    end
  endtask

  task automatic test_ignored_and_priority();
    do_reset();
    press(0);
    press(2);
    checks++; if (state_out !== 2'd1) begin failures++; $display("FAIL clr_in_run got=%0d exp=1", state_out); end
    press(0);
    press(1);
    checks++; if (state_out !== 2'd2) begin failures++; $display("FAIL lap_in_pause got=%0d exp=2", state_out); end
    press(0);
    start_stop = 1'b1; lap = 1'b1;
    cyc();
    start_stop = 1'b0; lap = 1'b0;
    cyc(); cyc(); cyc();
    checks++; if (state_out !== 2'd2) begin failures++; $display("FAIL ss_over_lap got=%0d exp=2", state_out); end
  endtask

`ifdef STOPWATCH_LAP_EN
  task automatic test_lap();
    do_reset();
    hour_in = 5'd0; min_in = 6'd1; sec_in = 6'd7;
    press(0);
    press(1);
    checks++; if (state_out !== 2'd3) begin failures++; $display("FAIL lap_enter got=%0d exp=3", state_out); end
    sec_in = 6'd9;
    #1;
    checks++; if ({hour_out, min_out, sec_out} !== {5'd0, 6'd1, 6'd7}) begin failures++; $display("FAIL lap_frozen got=%0d/%0d/%0d exp=0/1/7", hour_out, min_out, sec_out); end
    lap = 1'b1;
    cyc();
    lap = 1'b0;
    cyc(); cyc();
    checks++; if (state_out !== 2'd3 || {hour_out, min_out, sec_out} !== {5'd0, 6'd1, 6'd7}) begin failures++; $display("FAIL lap_hold st=%0d got=%0d/%0d/%0d exp st=3 0/1/7", state_out, hour_out, min_out, sec_out); end
    cyc();
    checks++; if (state_out !== 2'd1 || {hour_out, min_out, sec_out} !== {5'd0, 6'd1, 6'd9}) begin failures++; $display("FAIL lap_release st=%0d got=%0d/%0d/%0d exp st=1 0/1/9", state_out, hour_out, min_out, sec_out); end
  endtask

  task automatic test_reset_mid_lap();
    do_reset();
    hour_in = 5'd0; min_in = 6'd1; sec_in = 6'd7;
    press(0);
    press(1);
    cyc(); cyc(); cyc();
    checks++; if (state_out !== 2'd3 || count_en !== 1'b1) begin failures++; $display("FAIL lap_counting st=%0d en=%b exp st=3 en=1", state_out, count_en); end
    hour_in = 5'd2; min_in = 6'd3; sec_in = 6'd4;
    #1;
    resetn = 1'b0;
    #1;
    checks++; if (state_out !== 2'd0 || count_en !== 1'b0 || count_clr !== 1'b0) begin failures++; $display("FAIL lap_async_reset st=%0d en=%b clr=%b exp 0 0 0", state_out, count_en, count_clr); end
    checks++; if ({hour_out, min_out, sec_out} !== {5'd2, 6'd3, 6'd4}) begin failures++; $display("FAIL lap_reset_live got=%0d/%0d/%0d exp=2/3/4", hour_out, min_out, sec_out); end
    cyc();
    resetn = 1'b1;
  endtask
`else
  task automatic test_no_lap();
    do_reset();
    hour_in = 5'd0; min_in = 6'd1; sec_in = 6'd7;
    press(0);
    press(1);
    checks++; if (state_out !== 2'd1) begin failures++; $display("FAIL nolap_state got=%0d exp=1", state_out); end
    sec_in = 6'd9;
    #1;
    checks++; if ({hour_out, min_out, sec_out} !== {5'd0, 6'd1, 6'd9}) begin failures++; $display("FAIL nolap_live got=%0d/%0d/%0d exp=0/1/9", hour_out, min_out, sec_out); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (state_out !== 2'd1) begin failures++; $display("FAIL nolap_stays cyc=%0d got=%0d exp=1", i, state_out); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start_run();
    test_held_through_reset();
    test_pause_resume();
    test_clear_priority();
    test_ignored_and_priority();
`ifdef STOPWATCH_LAP_EN
    test_lap();
    test_reset_mid_lap();
`else
    test_no_lap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
